// File: rtl/lebug_trace_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lebug_trace_pkg
// Purpose : Dump FSM state encoding and pointer/count width helpers.
// Rev     : 1.0
// ============================================================================
package lebug_trace_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } dump_state_t;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Count must represent DEPTH itself, hence one extra bit.
  function automatic int count_width(input int depth);
    return ptr_width(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trace_mem.sv
`default_nettype none
// ============================================================================
// Module  : trace_mem
// Purpose : Simple dual-port RAM, one write port, registered read, no reset.
// Rev     : 1.0
// ============================================================================
module trace_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 256,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read data holds when rd_en is low, so a stalled consumer sees a stable word.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/vector_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module  : vector_trace_buffer
// Purpose : Circular vector trace capture with oldest-first handshake dump.
// Rev     : 1.0
// ============================================================================
module vector_trace_buffer
  import lebug_trace_pkg::*;
#(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tracing,
  input  logic                          valid_in,
  input  logic [N*DATA_WIDTH-1:0]       vector_in,
  input  logic                          start_dump,
  input  logic                          ready_in,
  output logic [N*DATA_WIDTH-1:0]       vector_out,
  output logic                          valid_out,
  output logic                          dump_busy,
  output logic                          dump_done,
  output logic [count_width(DEPTH)-1:0] count
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = count_width(DEPTH);
  localparam int DW = N * DATA_WIDTH;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  dump_state_t   state;
  dump_state_t   state_nx;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] remaining;
  logic [PW-1:0] wr_base;
  logic [CW-1:0] cnt_base;
  logic          wr_en;
  logic          rd_en;
  logic          dump_req;
  logic          xfer;
  logic [DW-1:0] rd_data;

  assign wr_en    = tracing && valid_in;
  assign dump_req = (state == IDLE) && start_dump && !tracing;
  assign rd_en    = (state == FETCH) && !tracing;
  assign xfer     = valid_out && ready_in && !tracing;

  // DONE clears the trace; a capture in that same cycle starts from entry 0.
  assign wr_base  = (state == DONE) ? '0 : wr_ptr;
  assign cnt_base = (state == DONE) ? '0 : count;

  trace_mem #(
    .DEPTH (DEPTH),
    .WIDTH (DW),
    .AW    (PW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_base),
    .wr_data (vector_in),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    valid_out = 1'b0;
    dump_busy = 1'b0;
    dump_done = 1'b0;
    case (state)
      IDLE: begin
        if (dump_req) begin
          state_nx = (count == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        dump_busy = 1'b1;
        state_nx  = tracing ? IDLE : PRESENT;
      end
      PRESENT: begin
        dump_busy = 1'b1;
        valid_out = 1'b1;
        if (tracing) begin
          state_nx = IDLE;
        end else if (xfer) begin
          state_nx = (remaining == CW'(1)) ? DONE : FETCH;
        end
      end
      DONE: begin
        dump_done = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign vector_out = valid_out ? rd_data : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      count     <= '0;
      rd_ptr    <= '0;
      remaining <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_base + PW'(1);
        count  <= (cnt_base == FULL) ? FULL : cnt_base + CW'(1);
      end else if (state == DONE) begin
        wr_ptr <= '0;
        count  <= '0;
      end

      // When full, wr_ptr points at the oldest entry.
      if (dump_req) begin
        rd_ptr    <= (count == FULL) ? wr_ptr : '0;
        remaining <= count;
      end else if (xfer) begin
        rd_ptr    <= rd_ptr + PW'(1);
        remaining <= remaining - CW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vector_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_vector_trace_buffer
// Purpose : Directed table-driven bench for vector_trace_buffer.
// Rev     : 1.0
// ============================================================================
module tb_vector_trace_buffer;

  localparam int N     = 8;
  localparam int DWL   = 32;
  localparam int DEPTH = 16;
  localparam int DW    = N * DWL;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tracing;
  logic          valid_in;
  logic [DW-1:0] vector_in;
  logic          start_dump;
  logic          ready_in;
  logic [DW-1:0] vector_out;
  logic          valid_out;
  logic          dump_busy;
  logic          dump_done;
  logic [4:0]    count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int nwr;
    int exp_count;
    int exp_first;
  } vec_t;

  vec_t tbl[5];

  vector_trace_buffer #(
    .N          (N),
    .DATA_WIDTH (DWL),
    .DEPTH      (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tracing    (tracing),
    .valid_in   (valid_in),
    .vector_in  (vector_in),
    .start_dump (start_dump),
    .ready_in   (ready_in),
    .vector_out (vector_out),
    .valid_out  (valid_out),
    .dump_busy  (dump_busy),
    .dump_done  (dump_done),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mkvec(input int val);
    logic [DW-1:0] v;
    for (int l = 0; l < N; l++) begin
      v[l*DWL +: DWL] = DWL'(val) | (DWL'(l) << 24);
    end
    return v;
  endfunction

  task automatic write_vecs(input int first, input int n);
    tracing = 1'b1;
    for (int i = 0; i < n; i++) begin
      valid_in  = 1'b1;
      vector_in = mkvec(first + i);
      tick();
    end
    valid_in = 1'b0;
    tracing  = 1'b0;
  endtask

  task automatic run_dump(input int first, input int n, input bit toggle);
    int            idx = 0;
    int            cyc = 0;
    int            last = -10;
    bit            done_seen = 1'b0;
    bit            held = 1'b0;
    logic [DW-1:0] hv = '0;
    tracing    = 1'b0;
    ready_in   = 1'b1;
    start_dump = 1'b1;
    tick();
    start_dump = 1'b0;
    while (!done_seen && cyc < 400) begin
      if (toggle) ready_in = ((cyc % 2) == 0);
      if (held) begin
        chk("stall_valid", valid_out, 1'b1);
        chk("stall_hold", vector_out, hv);
      end
      held = 1'b0;
      if (valid_out) begin
        if (ready_in) begin
          chk("dump_data", vector_out, mkvec(first + idx));
          idx++;
          last = cyc;
        end else begin
          held = 1'b1;
          hv   = vector_out;
        end
      end else begin
        chk("zero_when_invalid", vector_out, '0);
      end
      if (dump_done) begin
        done_seen = 1'b1;
        chk("done_latency", cyc, last + 1);
      end else begin
        tick();
        cyc++;
      end
    end
    if (!done_seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL dump_timeout: no dump_done after %0d cycles", cyc);
    end
    chk("dump_len", idx, n);
    tick();
    chk("done_pulse_width", dump_done, 1'b0);
    chk("count_after_dump", count, '0);
    ready_in = 1'b0;
  endtask

  initial begin
    int  acc;
    int  cyc;
    bit  seen;

    tbl[0] = '{nwr: 5,  exp_count: 5,  exp_first: 1};
    tbl[1] = '{nwr: 20, exp_count: 16, exp_first: 5};
    tbl[2] = '{nwr: 16, exp_count: 16, exp_first: 1};
    tbl[3] = '{nwr: 1,  exp_count: 1,  exp_first: 1};
    tbl[4] = '{nwr: 17, exp_count: 16, exp_first: 2};

    rst_n = 1'b0; tracing = 1'b0; valid_in = 1'b0; vector_in = '0;
    start_dump = 1'b0; ready_in = 1'b0;
    repeat (3) tick();
    chk("rst_count", count, '0);
    chk("rst_valid", valid_out, 1'b0);
    chk("rst_busy", dump_busy, 1'b0);
    chk("rst_done", dump_done, 1'b0);
    chk("rst_vector", vector_out, '0);
    rst_n = 1'b1;
    tick();

    for (int t = 0; t < 5; t++) begin
      write_vecs(1, tbl[t].nwr);
      chk("tbl_count", count, tbl[t].exp_count);
      run_dump(tbl[t].exp_first, tbl[t].exp_count, 1'b0);
    end

    // valid_in ignored while not tracing
    valid_in = 1'b1; vector_in = mkvec(77);
    repeat (2) tick();
    valid_in = 1'b0;
    chk("ignore_valid_count", count, '0);

    // Stalled consumer
    write_vecs(101, 4);
    chk("stall_count", count, 5'd4);
    run_dump(101, 4, 1'b1);

    // Abort mid-dump
    write_vecs(201, 5);
    ready_in = 1'b1; start_dump = 1'b1;
    tick();
    start_dump = 1'b0;
    acc = 0; cyc = 0;
    while (acc < 2 && cyc < 50) begin
      if (valid_out) begin
        chk("abort_data", vector_out, mkvec(201 + acc));
        acc++;
      end
      tick();
      cyc++;
    end
    tracing = 1'b1; ready_in = 1'b0;
    tick();
    chk("abort_valid", valid_out, 1'b0);
    chk("abort_busy", dump_busy, 1'b0);
    chk("abort_count", count, 5'd5);
    seen = dump_done;
    repeat (4) begin
      tick();
      seen = seen | dump_done;
    end
    chk("abort_no_done", seen, 1'b0);
    valid_in = 1'b1; vector_in = mkvec(206);
    tick();
    valid_in = 1'b0;
    chk("abort_resume_count", count, 5'd6);
    run_dump(201, 6, 1'b0);

    // Empty dump
    start_dump = 1'b1;
    tick();
    start_dump = 1'b0;
    chk("empty_valid", valid_out, 1'b0);
    chk("empty_done", dump_done, 1'b1);
    chk("empty_busy", dump_busy, 1'b0);
    tick();
    chk("empty_done_width", dump_done, 1'b0);

    // Reset during PRESENT
    write_vecs(301, 3);
    ready_in = 1'b0; start_dump = 1'b1;
    tick();
    start_dump = 1'b0;
    cyc = 0;
    while (!valid_out && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("present_reached", valid_out, 1'b1);
    rst_n = 1'b0; start_dump = 1'b1; tracing = 1'b1; valid_in = 1'b1;
    vector_in = mkvec(999);
    tick();
    chk("midrst_valid", valid_out, 1'b0);
    chk("midrst_count", count, '0);
    chk("midrst_busy", dump_busy, 1'b0);
    chk("midrst_done", dump_done, 1'b0);
    chk("midrst_vector", vector_out, '0);
    tick();
    chk("midrst_count2", count, '0);
    chk("midrst_busy2", dump_busy, 1'b0);
    rst_n = 1'b1; start_dump = 1'b0; tracing = 1'b0; valid_in = 1'b0;
    tick();
    chk("postrst_count", count, '0);
    chk("postrst_busy", dump_busy, 1'b0);
    chk("postrst_valid", valid_out, 1'b0);

    write_vecs(401, 2);
    chk("postrst_wr_count", count, 5'd2);
    run_dump(401, 2, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
